// File: rtl/mem_responder_if.sv
// mem_responder_if: bus between the CPU controller (master) and the memory responder (slave).
// Requests:  ram_ena/ram_read/ram_write, rom_ena/rom_read, addr, wdata
// Preload:   rom_wr, rom_wr_addr, rom_wr_data
// Responses: rdata, rdata_valid, ack, ready, err
// MEM_PARITY_EN adds par_inj (master -> slave), which corrupts the stored parity bit on a write.
interface mem_responder_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 5
);
    logic          ram_ena;
    logic          ram_read;
    logic          ram_write;
    logic          rom_ena;
    logic          rom_read;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          rom_wr;
    logic [AW-1:0] rom_wr_addr;
    logic [DW-1:0] rom_wr_data;
`ifdef MEM_PARITY_EN
    logic          par_inj;
`endif
    logic [DW-1:0] rdata;
    logic          rdata_valid;
    logic          ack;
    logic          ready;
    logic          err;

    modport master (
        output ram_ena, ram_read, ram_write, rom_ena, rom_read, addr, wdata,
        output rom_wr, rom_wr_addr, rom_wr_data,
`ifdef MEM_PARITY_EN
        output par_inj,
`endif
        input  rdata, rdata_valid, ack, ready, err
    );

    modport slave (
        input  ram_ena, ram_read, ram_write, rom_ena, rom_read, addr, wdata,
        input  rom_wr, rom_wr_addr, rom_wr_data,
`ifdef MEM_PARITY_EN
        input  par_inj,
`endif
        output rdata, rdata_valid, ack, ready, err
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the 8-bit RISC CPU bus.
// Serves ROM reads, RAM reads and RAM writes through a WAIT_CYC wait-state sequencer
// (IDLE -> WAIT -> RESP), returning rdata with a one-cycle rdata_valid or a one-cycle ack.
// A preload port (rom_wr*) fills the ROM. Conflicting selects and preload/read collisions
// produce a registered one-cycle err pulse.
// Ports:
//   clk_i  - clock, rising edge
//   rst_ni - synchronous active-low reset
//   bus    - mem_responder_if.slave (requests, preload, responses)
// Build option: define MEM_PARITY_EN to store an even-parity bit per RAM word and flag
// mismatches on read with err alongside rdata_valid (adds bus.par_inj).
module mem_responder #(
    parameter int unsigned DW       = 8,
    parameter int unsigned AW       = 5,
    parameter int unsigned WAIT_CYC = 1
) (
    input logic            clk_i,
    input logic            rst_ni,
    mem_responder_if.slave bus
);
    localparam int unsigned Depth = 2 ** AW;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;
    typedef enum logic [1:0] {KindRomRd, KindRamRd, KindRamWr} kind_e;

    state_e        state_q, state_d;
    kind_e         kind_q, kind_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          valid_q, valid_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;

    logic [DW-1:0] rom_mem [Depth];
    logic [DW-1:0] ram_mem [Depth];
`ifdef MEM_PARITY_EN
    logic          ram_par [Depth];
`endif

    logic          rom_rd_req, ram_rd_req, ram_wr_req, any_req, conflict;
    logic          conflict_err, enter_resp;
    kind_e         acc_kind;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] acc_wdata;
    logic          ram_we, rom_we, collide, par_err;

    // Request decode; the three request kinds are disjoint from the conflict terms.
    assign rom_rd_req = bus.rom_ena & bus.rom_read & ~bus.ram_ena;
    assign ram_rd_req = bus.ram_ena & bus.ram_read & ~bus.ram_write & ~bus.rom_ena;
    assign ram_wr_req = bus.ram_ena & bus.ram_write & ~bus.ram_read & ~bus.rom_ena;
    assign any_req    = rom_rd_req | ram_rd_req | ram_wr_req;
    assign conflict   = (bus.rom_ena & bus.ram_ena) |
                        (bus.ram_ena & bus.ram_read & bus.ram_write);

    // FSM next state. acc_* describe the access performed on the edge entering RESP:
    // the live request when WAIT_CYC is 0, otherwise the latched copy.
    always_comb begin
        state_d      = state_q;
        kind_d       = kind_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        conflict_err = 1'b0;
        enter_resp   = 1'b0;
        acc_kind     = kind_q;
        acc_addr     = addr_q;
        acc_wdata    = wdata_q;
        unique case (state_q)
            StIdle: begin
                if (conflict) begin
                    conflict_err = 1'b1;
                end else if (any_req) begin
                    kind_d  = rom_rd_req ? KindRomRd : (ram_rd_req ? KindRamRd : KindRamWr);
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    if (WAIT_CYC > 0) begin
                        state_d = StWait;
                        cnt_d   = 4'(WAIT_CYC - 1);
                    end else begin
                        state_d    = StResp;
                        enter_resp = 1'b1;
                        acc_kind   = kind_d;
                        acc_addr   = bus.addr;
                        acc_wdata  = bus.wdata;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d    = StResp;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Memory side effects and registered responses.
    always_comb begin
        ram_we  = enter_resp & (acc_kind == KindRamWr);
        // A preload aimed at the word being read on this edge loses; the read sees the old word.
        collide = enter_resp & (acc_kind == KindRomRd) & bus.rom_wr &
                  (bus.rom_wr_addr == acc_addr);
        rom_we  = bus.rom_wr & ~collide;
`ifdef MEM_PARITY_EN
        par_err = enter_resp & (acc_kind == KindRamRd) &
                  ((^ram_mem[acc_addr]) != ram_par[acc_addr]);
`else
        par_err = 1'b0;
`endif
        rdata_d = rdata_q;
        if (enter_resp && acc_kind == KindRomRd) begin
            rdata_d = rom_mem[acc_addr];
        end else if (enter_resp && acc_kind == KindRamRd) begin
            rdata_d = ram_mem[acc_addr];
        end
        valid_d = enter_resp & (acc_kind != KindRamWr);
        ack_d   = ram_we;
        err_d   = conflict_err | collide | par_err;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            kind_q  <= KindRomRd;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            valid_q <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            valid_q <= valid_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    // Contents are not reset, but no write may commit while reset is held.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            if (ram_we) begin
                ram_mem[acc_addr] <= acc_wdata;
`ifdef MEM_PARITY_EN
                ram_par[acc_addr] <= (^acc_wdata) ^ bus.par_inj;
`endif
            end
            if (rom_we) begin
                rom_mem[bus.rom_wr_addr] <= bus.rom_wr_data;
            end
        end
    end

    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = valid_q;
    assign bus.ack         = ack_q;
    assign bus.err         = err_q;
    assign bus.ready       = (state_q == StIdle);
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed bench for mem_responder. dut1 runs with one wait state and takes
// a vector table plus corner sequences; dut0 runs with zero wait states for back-to-back reads.
module tb_mem_responder;
    localparam int unsigned DW      = 8;
    localparam int unsigned AW      = 5;
    localparam int unsigned WaitCyc = 1;

    localparam logic [1:0] OpRomRd = 2'd0;
    localparam logic [1:0] OpRamRd = 2'd1;
    localparam logic [1:0] OpRamWr = 2'd2;

    logic clk = 1'b0;
    logic rst_n1;
    logic rst_n0;
    always #5 clk = ~clk;

    mem_responder_if #(.DW(DW), .AW(AW)) bus1 ();
    mem_responder_if #(.DW(DW), .AW(AW)) bus0 ();

    mem_responder #(.DW(DW), .AW(AW), .WAIT_CYC(WaitCyc)) dut1 (
        .clk_i (clk),
        .rst_ni(rst_n1),
        .bus   (bus1)
    );

    mem_responder #(.DW(DW), .AW(AW), .WAIT_CYC(0)) dut0 (
        .clk_i (clk),
        .rst_ni(rst_n0),
        .bus   (bus0)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]    op;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clear1();
        bus1.ram_ena   = 1'b0;
        bus1.ram_read  = 1'b0;
        bus1.ram_write = 1'b0;
        bus1.rom_ena   = 1'b0;
        bus1.rom_read  = 1'b0;
    endtask

    // All sequences start and end in the drive phase, 1 time unit after a rising edge.
    task automatic preload1(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus1.rom_wr      = 1'b1;
        bus1.rom_wr_addr = a;
        bus1.rom_wr_data = d;
        @(posedge clk); #1;
        bus1.rom_wr = 1'b0;
    endtask

    task automatic preload0(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus0.rom_wr      = 1'b1;
        bus0.rom_wr_addr = a;
        bus0.rom_wr_data = d;
        @(posedge clk); #1;
        bus0.rom_wr = 1'b0;
    endtask

    // One transaction on dut1: strobes held for one sampling edge, then wait for the pulse.
    task automatic run_txn(input string name, input logic [1:0] op, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input logic [DW-1:0] exp);
        int lat;
        lat = 0;
        bus1.addr  = a;
        bus1.wdata = wd;
        if (op == OpRomRd) begin
            bus1.rom_ena = 1'b1; bus1.rom_read = 1'b1;
        end else if (op == OpRamRd) begin
            bus1.ram_ena = 1'b1; bus1.ram_read = 1'b1;
        end else begin
            bus1.ram_ena = 1'b1; bus1.ram_write = 1'b1;
        end
        check({name, ".ready_before"}, 32'(bus1.ready), 32'd1);
        @(posedge clk); #1;
        clear1();
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check({name, ".ready_busy"}, 32'(bus1.ready), 32'd0);
            if (bus1.rdata_valid || bus1.ack) begin
                lat = i;
                break;
            end
        end
        check({name, ".latency"}, 32'(lat), 32'(WaitCyc + 1));
        check({name, ".err"}, 32'(bus1.err), 32'd0);
        if (op == OpRamWr) begin
            check({name, ".ack"}, {31'd0, bus1.ack}, 32'd1);
            check({name, ".valid_on_write"}, 32'(bus1.rdata_valid), 32'd0);
        end else begin
            check({name, ".valid"}, 32'(bus1.rdata_valid), 32'd1);
            check({name, ".ack_on_read"}, 32'(bus1.ack), 32'd0);
            check({name, ".rdata"}, 32'(bus1.rdata), 32'(exp));
        end
        @(negedge clk);
        check({name, ".pulse_end"}, {30'd0, bus1.rdata_valid, bus1.ack}, 32'd0);
        check({name, ".ready_after"}, 32'(bus1.ready), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{OpRamWr, 5'd7,  8'h3C, 8'h00};
        vecs[1] = '{OpRamRd, 5'd7,  8'h00, 8'h3C};
        vecs[2] = '{OpRomRd, 5'd3,  8'h00, 8'hA5};
        vecs[3] = '{OpRamWr, 5'd0,  8'hFF, 8'h00};
        vecs[4] = '{OpRamWr, 5'd31, 8'h01, 8'h00};
        vecs[5] = '{OpRamRd, 5'd0,  8'h00, 8'hFF};
        vecs[6] = '{OpRamRd, 5'd31, 8'h00, 8'h01};
        vecs[7] = '{OpRomRd, 5'd31, 8'h00, 8'h5A};
        vecs[8] = '{OpRomRd, 5'd0,  8'h00, 8'hC3};
        vecs[9] = '{OpRamWr, 5'd2,  8'h11, 8'h00};

        clear1();
        bus1.addr = '0; bus1.wdata = '0;
        bus1.rom_wr = 1'b0; bus1.rom_wr_addr = '0; bus1.rom_wr_data = '0;
        bus0.ram_ena = 1'b0; bus0.ram_read = 1'b0; bus0.ram_write = 1'b0;
        bus0.rom_ena = 1'b0; bus0.rom_read = 1'b0;
        bus0.addr = '0; bus0.wdata = '0;
        bus0.rom_wr = 1'b0; bus0.rom_wr_addr = '0; bus0.rom_wr_data = '0;
`ifdef MEM_PARITY_EN
        bus1.par_inj = 1'b0;
        bus0.par_inj = 1'b0;
`endif
        rst_n1 = 1'b0;
        rst_n0 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.ready1", 32'(bus1.ready), 32'd1);
        check("reset.outs1", {bus1.rdata, bus1.rdata_valid, bus1.ack, bus1.err}, 32'd0);
        check("reset.ready0", 32'(bus0.ready), 32'd1);
        check("reset.outs0", {bus0.rdata, bus0.rdata_valid, bus0.ack, bus0.err}, 32'd0);
        @(posedge clk); #1;
        rst_n1 = 1'b1;
        rst_n0 = 1'b1;

        // Preload, then the vector table.
        preload1(5'd3, 8'hA5);
        preload1(5'd31, 8'h5A);
        preload1(5'd0, 8'hC3);
        for (int i = 0; i < 10; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].exp);
        end

        // Both selects high: err pulse, no access.
        bus1.rom_ena = 1'b1; bus1.rom_read = 1'b1;
        bus1.ram_ena = 1'b1; bus1.ram_write = 1'b1;
        bus1.addr = 5'd7; bus1.wdata = 8'h99;
        @(posedge clk); #1;
        clear1();
        @(negedge clk);
        check("conflict_sel.err", 32'(bus1.err), 32'd1);
        check("conflict_sel.ready", 32'(bus1.ready), 32'd1);
        check("conflict_sel.vld_ack", {30'd0, bus1.rdata_valid, bus1.ack}, 32'd0);
        @(negedge clk);
        check("conflict_sel.err_end", 32'(bus1.err), 32'd0);
        check("conflict_sel.vld_ack2", {30'd0, bus1.rdata_valid, bus1.ack}, 32'd0);
        @(posedge clk); #1;

        // Read and write strobes together.
        bus1.ram_ena = 1'b1; bus1.ram_read = 1'b1; bus1.ram_write = 1'b1;
        bus1.addr = 5'd7; bus1.wdata = 8'h55;
        @(posedge clk); #1;
        clear1();
        @(negedge clk);
        check("conflict_rw.err", 32'(bus1.err), 32'd1);
        check("conflict_rw.vld_ack", {30'd0, bus1.rdata_valid, bus1.ack}, 32'd0);
        @(posedge clk); #1;

        // ram_ena with no strobe: no-op, no err.
        bus1.ram_ena = 1'b1;
        @(posedge clk); #1;
        clear1();
        @(negedge clk);
        check("noop.err", 32'(bus1.err), 32'd0);
        check("noop.ready", 32'(bus1.ready), 32'd1);
        @(posedge clk); #1;
        run_txn("after_conflict", OpRamRd, 5'd7, 8'h00, 8'h3C);

        // Preload lands on the edge entering RESP of a ROM read to the same word.
        bus1.rom_ena = 1'b1; bus1.rom_read = 1'b1; bus1.addr = 5'd3;
        @(posedge clk); #1;
        clear1();
        bus1.rom_wr = 1'b1; bus1.rom_wr_addr = 5'd3; bus1.rom_wr_data = 8'hEE;
        @(posedge clk); #1;
        bus1.rom_wr = 1'b0;
        @(negedge clk);
        check("collide.valid", 32'(bus1.rdata_valid), 32'd1);
        check("collide.rdata", 32'(bus1.rdata), 32'hA5);
        check("collide.err", 32'(bus1.err), 32'd1);
        @(posedge clk); #1;
        run_txn("collide_readback", OpRomRd, 5'd3, 8'h00, 8'hA5);

        // Reset during WAIT of a write to addr 2 (holds 8'h11).
        bus1.ram_ena = 1'b1; bus1.ram_write = 1'b1; bus1.addr = 5'd2; bus1.wdata = 8'h77;
        @(posedge clk); #1;
        clear1();
        rst_n1 = 1'b0;
        @(negedge clk);
        check("rst_mid.ready_wait", 32'(bus1.ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_mid.ready", 32'(bus1.ready), 32'd1);
        check("rst_mid.outs", {bus1.rdata, bus1.rdata_valid, bus1.ack, bus1.err}, 32'd0);
        @(posedge clk); #1;
        rst_n1 = 1'b1;
        @(negedge clk);
        check("rst_mid.no_ack", 32'(bus1.ack), 32'd0);
        @(posedge clk); #1;
        run_txn("rst_readback", OpRamRd, 5'd2, 8'h00, 8'h11);

`ifdef MEM_PARITY_EN
        bus1.par_inj = 1'b1;
        run_txn("par_write", OpRamWr, 5'd4, 8'h5B, 8'h00);
        bus1.par_inj = 1'b0;
        bus1.ram_ena = 1'b1; bus1.ram_read = 1'b1; bus1.addr = 5'd4;
        @(posedge clk); #1;
        clear1();
        @(negedge clk);
        @(negedge clk);
        check("parity.valid", 32'(bus1.rdata_valid), 32'd1);
        check("parity.err", 32'(bus1.err), 32'd1);
        check("parity.rdata", 32'(bus1.rdata), 32'h5B);
        @(posedge clk); #1;
`endif

        // Zero wait states: strobes held, address changed while in RESP.
        preload0(5'd0, 8'h10);
        preload0(5'd1, 8'h21);
        bus0.rom_ena = 1'b1; bus0.rom_read = 1'b1; bus0.addr = 5'd0;
        @(posedge clk); #1;
        bus0.addr = 5'd1;
        @(negedge clk);
        check("b2b.valid0", 32'(bus0.rdata_valid), 32'd1);
        check("b2b.rdata0", 32'(bus0.rdata), 32'h10);
        check("b2b.ready0", 32'(bus0.ready), 32'd0);
        @(negedge clk);
        check("b2b.gap", 32'(bus0.rdata_valid), 32'd0);
        check("b2b.gap_ready", 32'(bus0.ready), 32'd1);
        @(negedge clk);
        check("b2b.valid1", 32'(bus0.rdata_valid), 32'd1);
        check("b2b.rdata1", 32'(bus0.rdata), 32'h21);
        bus0.rom_ena = 1'b0; bus0.rom_read = 1'b0;
        @(negedge clk);
        check("b2b.end", 32'(bus0.rdata_valid), 32'd0);
        check("b2b.hold", 32'(bus0.rdata), 32'h21);
        @(negedge clk);
        check("b2b.idle", {bus0.ready, bus0.rdata_valid, bus0.err}, 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
